// File: rtl/if_stage_pc.sv
// Instruction-fetch stage: owns the PC and the IF/ID register.
// Fixed-priority next-PC selection with a one-bubble squash on every taken redirect.
module if_stage_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0004,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        do_jr;
    logic        do_br;
    logic        do_j;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    assign br_tgt = id_pc_plus4
                  + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign j_tgt  = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

    // A bubble in ID carries no decision, so it can never redirect.
    assign do_jr = jr && id_valid;
    assign do_br = branch_taken && id_valid;
    assign do_j  = jump && id_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= NOP;
            id_pc_plus4 <= RESET_PC;
            id_valid    <= 1'b0;
        end else if (exc_req) begin
            pc          <= EXC_PC;
            id_instr    <= NOP;
            id_pc_plus4 <= EXC_PC;
            id_valid    <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
            id_instr    <= id_instr;
            id_pc_plus4 <= id_pc_plus4;
            id_valid    <= id_valid;
        end else if (do_jr) begin
            pc          <= jr_target;
            id_instr    <= NOP;
            id_pc_plus4 <= jr_target;
            id_valid    <= 1'b0;
        end else if (do_br) begin
            pc          <= br_tgt;
            id_instr    <= NOP;
            id_pc_plus4 <= br_tgt;
            id_valid    <= 1'b0;
        end else if (do_j) begin
            pc          <= j_tgt;
            id_instr    <= NOP;
            id_pc_plus4 <= j_tgt;
            id_valid    <= 1'b0;
        end else begin
            pc          <= pc_plus4;
            id_instr    <= imem_rdata;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_pc.sv
// Testbench for if_stage_pc: directed scenarios then random traffic,
// all checked against an arithmetic reference model of the fetch stage.
module tb_if_stage_pc;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jr, exc_req;
    logic [31:0] jr_target, imem_rdata, imem_addr;
    logic [31:0] pc, id_instr, id_pc_plus4;
    logic        id_valid;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    always #5 clk = ~clk;

    if_stage_pc dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .jr(jr),
        .jr_target(jr_target), .exc_req(exc_req),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .pc(pc),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1000_0003;
            32'h0000_0040: return 32'h1000_FFFF;
            32'h0000_0044: return 32'h1000_0010;
            32'h9000_0000: return 32'h0800_0001;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch_taken = 0; jump = 0; jr = 0;
        exc_req = 0; jr_target = 32'h0;
    endtask

    // Reference model: next-state from the rules, checked one cycle later.
    task automatic step(input string tag);
        logic [31:0] n_pc, n_i, n_p, tgt;
        logic        n_v;
        int          off;
        n_pc = m_pc; n_i = m_instr; n_p = m_pp4; n_v = m_valid;
        if (reset) begin
            n_pc = RST_PC; n_i = 0; n_p = RST_PC; n_v = 0;
        end else if (exc_req) begin
            n_pc = EXC_PC; n_i = 0; n_p = EXC_PC; n_v = 0;
        end else if (stall) begin
            n_v = m_valid;
        end else if (m_valid && (jr || branch_taken || jump)) begin
            if (jr) tgt = jr_target;
            else if (branch_taken) begin
                off = $signed(m_instr[15:0]);
                tgt = m_pp4 + 32'(off * 4);
            end else
                tgt = (m_pp4 & 32'hF000_0000) | (32'(m_instr[25:0]) << 2);
            n_pc = tgt; n_i = 0; n_p = tgt; n_v = 0;
        end else begin
            n_pc = m_pc + 32'd4; n_i = imem_word(m_pc);
            n_p = m_pc + 32'd4; n_v = 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_i; m_pp4 = n_p; m_valid = n_v;
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".pp4"}, id_pc_plus4, m_pp4);
        chk({tag, ".valid"}, 32'(id_valid), 32'(m_valid));
    endtask

    initial begin
        m_pc = 'x; m_instr = 'x; m_pp4 = 'x; m_valid = 1'bx;
        idle();
        // 1: reset with random inputs, then sequential fetch
        repeat (2) begin
            reset = 1; stall = 1'($urandom); branch_taken = 1'($urandom);
            jump = 1'($urandom); jr = 1'($urandom); exc_req = 1'($urandom);
            jr_target = $urandom;
            step("rst");
        end
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        idle();
        step("seq0");
        chk("seq_first_pp4", id_pc_plus4, 32'h4);
        chk("seq_first_instr", id_instr, imem_word(32'h0));
        step("seq1");
        chk("seq_pc8", pc, 32'h8);
        step("seq2");
        chk("seq_pc12", pc, 32'hC);
        // 2: taken beq at 0x10
        while (id_pc_plus4 != 32'h14 && tests < 400) step("walk2");
        chk("beq_at", id_pc_plus4, 32'h14);
        branch_taken = 1;
        step("beq");
        chk("beq_pc", pc, 32'h20);
        chk("beq_bubble", 32'(id_valid), 32'h0);
        branch_taken = 0;
        step("beq1");
        chk("beq_tgt_in_id", id_instr, imem_word(32'h20));
        // 3: backward branch to itself, then not-taken
        while (id_pc_plus4 != 32'h44 && tests < 800) step("walk3");
        branch_taken = 1;
        step("loop");
        chk("loop_pc", pc, 32'h40);
        chk("loop_bubble", 32'(id_valid), 32'h0);
        branch_taken = 0;
        step("loop1");
        step("nt");
        chk("nt_pc", pc, 32'h48);
        chk("nt_valid", 32'(id_valid), 32'h1);
        // 4: stall masks a taken branch, then redirect exactly once
        stall = 1; branch_taken = 1;
        step("stall0");
        step("stall1");
        chk("stall_pc", pc, 32'h48);
        stall = 0;
        step("stall_rel");
        chk("stall_redirect", pc, 32'h88);
        step("stall_bubble_ignored");
        chk("once_pc", pc, 32'h8C);
        branch_taken = 0;
        // 5: jr beats branch; exception beats stall
        jr = 1; branch_taken = 1; jr_target = 32'h100;
        step("jr");
        chk("jr_pc", pc, 32'h100);
        idle();
        step("jr1");
        exc_req = 1; stall = 1;
        step("exc");
        chk("exc_pc", pc, EXC_PC);
        chk("exc_valid", 32'(id_valid), 32'h0);
        idle();
        step("exc1");
        // 6: pc wrap and j target composition
        jr = 1; jr_target = 32'hFFFF_FFFC;
        step("jr_wrap");
        idle();
        step("wrap");
        chk("wrap_pc", pc, 32'h0);
        jr = 1; jr_target = 32'h9000_0000;
        step("jr9");
        idle();
        step("fetch9");
        jump = 1;
        step("j");
        chk("j_pc", pc, 32'h9000_0004);
        step("j_bubble_ignored");
        idle();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(99) < 2);
            exc_req      = ($urandom_range(99) < 3);
            stall        = ($urandom_range(99) < 20);
            jr           = ($urandom_range(99) < 10);
            branch_taken = ($urandom_range(99) < 15);
            jump         = ($urandom_range(99) < 10);
            jr_target    = ($urandom_range(3) == 0) ? $urandom
                           : ($urandom & 32'hFFFF_FFFC);
            step("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
